// File: rtl/mdu_param.sv
// Multiply/divide unit with architectural HI/LO, fixed-latency long ops and
// combinational mfhi/mflo read port.
module mdu_param #(
    parameter int WIDTH   = 32,
    parameter int MUL_LAT = 5,
    parameter int DIV_LAT = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       MDUOp,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO,
    output logic [WIDTH-1:0] Out,
    output logic             busy,
    output logic             done
);
    localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int CNT_W   = $clog2(MAX_LAT + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DIV  = 2'd2;

    localparam logic [3:0] OP_MULT  = 4'b0001;
    localparam logic [3:0] OP_MULTU = 4'b0010;
    localparam logic [3:0] OP_DIV   = 4'b0011;
    localparam logic [3:0] OP_DIVU  = 4'b0100;
    localparam logic [3:0] OP_MFHI  = 4'b0101;
    localparam logic [3:0] OP_MFLO  = 4'b0110;
    localparam logic [3:0] OP_MTHI  = 4'b0111;
    localparam logic [3:0] OP_MTLO  = 4'b1000;
    localparam logic [3:0] OP_MADD  = 4'b1001;
    localparam logic [3:0] OP_MADDU = 4'b1010;
    localparam logic [3:0] OP_MSUB  = 4'b1011;
    localparam logic [3:0] OP_MSUBU = 4'b1100;

    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    logic [1:0]         state;
    logic [CNT_W-1:0]   cnt;
    logic [3:0]         op_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] res;
    logic               accept;
    logic               mul_signed;

    // Operands are widened to 2*WIDTH before multiplying so the truncated
    // product is exact for both signed and unsigned interpretations.
    function automatic logic [2*WIDTH-1:0] mul_full(input logic [WIDTH-1:0] x,
                                                    input logic [WIDTH-1:0] y,
                                                    input logic sgn);
        logic signed [2*WIDTH-1:0] xs;
        logic signed [2*WIDTH-1:0] ys;
        xs = sgn ? {{WIDTH{x[WIDTH-1]}}, x} : {{WIDTH{1'b0}}, x};
        ys = sgn ? {{WIDTH{y[WIDTH-1]}}, y} : {{WIDTH{1'b0}}, y};
        return xs * ys;
    endfunction

    // Returns {remainder, quotient}; divide-by-zero leaves {HI,LO} as they were.
    function automatic logic [2*WIDTH-1:0] div_full(input logic [WIDTH-1:0] x,
                                                    input logic [WIDTH-1:0] y,
                                                    input logic sgn,
                                                    input logic [2*WIDTH-1:0] hl);
        logic signed [WIDTH-1:0] q;
        logic signed [WIDTH-1:0] r;
        if (y == '0) begin
            return hl;
        end else if (sgn) begin
            if (x == MOST_NEG && y == '1) begin
                return {{WIDTH{1'b0}}, x};
            end
            q = $signed(x) / $signed(y);
            r = $signed(x) % $signed(y);
            return {r, q};
        end else begin
            return {x % y, x / y};
        end
    endfunction

    assign busy       = (state != S_IDLE);
    assign accept     = start && !busy;
    assign mul_signed = (op_q == OP_MULT) || (op_q == OP_MADD) || (op_q == OP_MSUB);

    always_comb begin
        prod = mul_full(a_q, b_q, mul_signed);
        res  = acc_q;
        case (op_q)
            OP_MULT, OP_MULTU: res = prod;
            OP_MADD, OP_MADDU: res = acc_q + prod;
            OP_MSUB, OP_MSUBU: res = acc_q - prod;
            OP_DIV:            res = div_full(a_q, b_q, 1'b1, acc_q);
            OP_DIVU:           res = div_full(a_q, b_q, 1'b0, acc_q);
            default:           res = acc_q;
        endcase
    end

    // Operand capture at accept; later input changes cannot reach the result.
    always_ff @(posedge clk) begin
        if (accept) begin
            op_q  <= MDUOp;
            a_q   <= A;
            b_q   <= B;
            acc_q <= {HI, LO};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            cnt   <= '0;
            HI    <= '0;
            LO    <= '0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        case (MDUOp)
                            OP_MTHI: HI <= A;
                            OP_MTLO: LO <= A;
                            OP_MULT, OP_MULTU, OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: begin
                                state <= S_MUL;
                                cnt   <= CNT_W'(MUL_LAT);
                            end
                            OP_DIV, OP_DIVU: begin
                                state <= S_DIV;
                                cnt   <= CNT_W'(DIV_LAT);
                            end
                            default: ;
                        endcase
                    end
                end
                S_MUL, S_DIV: begin
                    if (cnt == CNT_W'(1)) begin
                        state    <= S_IDLE;
                        cnt      <= '0;
                        {HI, LO} <= res;
                        done     <= 1'b1;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: begin
                    state <= S_IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    always_comb begin
        Out = '0;
        if (start && MDUOp == OP_MFHI) begin
            Out = HI;
        end else if (start && MDUOp == OP_MFLO) begin
            Out = LO;
        end
    end

endmodule

// File: doc/mdu_param.md
MDU_PARAM -- requirements
Module: mdu_param

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/HI/LO width in bits (legal: 8..64, even).
REQ-002 SHALL have parameter MUL_LAT, default 5, cycles busy for multiply-class ops (legal: >=1).
REQ-003 SHALL have parameter DIV_LAT, default 10, cycles busy for divide ops (legal: >=1).
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 start  input  1  operation request qualifier for MDUOp.
REQ-007 MDUOp  input  4  opcode: 0001 mult, 0010 multu, 0011 div, 0100 divu, 0101 mfhi, 0110 mflo, 0111 mthi, 1000 mtlo, 1001 madd, 1010 maddu, 1011 msub, 1100 msubu; others NOP.
REQ-008 A  input  WIDTH  operand A / rs.
REQ-009 B  input  WIDTH  operand B / rt.
REQ-010 HI  output  WIDTH  architectural HI register.
REQ-011 LO  output  WIDTH  architectural LO register.
REQ-012 Out  output  WIDTH  mfhi/mflo read data.
REQ-013 busy  output  1  long operation in flight; requests not accepted.
REQ-014 done  output  1  one-cycle pulse on the edge HI/LO take a long-op result.

Function
REQ-015 Request accepted at a rising edge only when start=1 and busy=0; start while busy SHALL be ignored with no state change.
REQ-016 Accepted long op (mult..divu, madd..msubu) SHALL latch opcode, A, B, and (for madd/msub) the current {HI,LO} at the accept edge; later input changes SHALL not affect the result.
REQ-017 FSM states IDLE, MUL, DIV; IDLE->MUL on accepted multiply-class, IDLE->DIV on accepted div/divu, MUL/DIV->IDLE when the down-counter reaches 1 at an edge.
REQ-018 busy SHALL be 1 for exactly MUL_LAT (MUL) or DIV_LAT (DIV) cycles, starting the cycle after the accept edge.
REQ-019 HI/LO SHALL hold pre-op values while busy and update on the edge busy falls; done=1 for the following cycle only.
REQ-020 mult/multu: {HI,LO} = signed/unsigned 2*WIDTH-bit product of A and B.
REQ-021 madd/maddu: {HI,LO} = {HI,LO} + product; msub/msubu: {HI,LO} = {HI,LO} - product; modulo 2^(2*WIDTH), signedness of product per op.
REQ-022 div: LO = quotient truncated toward zero, HI = remainder with sign of A; divu: unsigned quotient/remainder.
REQ-023 div with A = most-negative, B = -1: LO = A, HI = 0, no trap.
REQ-024 div/divu with B = 0: full DIV_LAT busy period and done pulse SHALL occur, HI/LO unchanged.
REQ-025 mthi/mtlo accepted: HI (resp. LO) = A on the accept edge; no busy, no done.
REQ-026 Out combinational: HI when start=1 and MDUOp=0101, LO when start=1 and MDUOp=0110, else 0; valid regardless of busy (stale-read hazard owned by pipeline stall logic).
REQ-027 NOP opcodes accepted with no state change.
REQ-028 done and accept of a new op MAY coincide: new op accepted on the first cycle busy=0 and reads updated HI/LO.

Reset
REQ-029 reset=1 at an edge SHALL force HI=0, LO=0, busy=0, done=0, FSM=IDLE, counter=0, overriding any start on that edge.
REQ-030 reset during MUL/DIV SHALL abort the op; no HI/LO update, no done pulse afterward.

Verification
REQ-031 mult A=0xFFFFFFFE, B=3 -> busy 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA, done 1 cycle.
REQ-032 mthi 0, mtlo 10, then maddu A=0xFFFFFFFF, B=2 -> HI=0x00000002, LO=0x00000008.
REQ-033 div A=-7 (0xFFFFFFF9), B=2 -> busy 10 cycles, LO=0xFFFFFFFD, HI=0xFFFFFFFF; divu B=0 -> busy 10 cycles, HI/LO unchanged.
REQ-034 mult accepted then start with mtlo A=5 during busy -> ignored; LO = product only.
REQ-035 reset asserted on cycle 3 of div -> busy=0, HI=LO=0 next cycle, no done pulse.
REQ-036 WIDTH=16 build: mult A=0x8000, B=0x8000 -> HI=0x4000, LO=0x0000; mfhi with start=1 -> Out=0x4000.
